// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    HDR   = 3'd0,
    DATA  = 3'd1,
    CSUM  = 3'd2,
    DONE  = 3'd3,
    ERROR = 3'd4
  } loader_state_t;

  localparam int LOADER_HDR_BYTES  = 4;
  localparam int LOADER_WORD_BYTES = 4;

  function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] data);
    return acc ^ data;
  endfunction

endpackage

// File: rtl/imem_loader_byte_word_packer.sv
// Little-endian byte-to-word packer: a lane counter plus an assembly register.
// word/word_valid are combinational so the caller can register the finished word on the last byte's edge.
module byte_word_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  input  logic [1:0]  last_lane,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  lane_r;
  logic [31:0] word_r;

  // Merge the incoming byte into its lane of the partially assembled word.
  always_comb begin
    word = word_r;
    case (lane_r)
      2'd0:    word[7:0]   = byte_in;
      2'd1:    word[15:8]  = byte_in;
      2'd2:    word[23:16] = byte_in;
      default: word[31:24] = byte_in;
    endcase
    word_valid = byte_en && (lane_r == last_lane);
  end

  // Lane counter and assembly register; state is held across s_valid gaps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_r <= 2'd0;
      word_r <= 32'd0;
    end else if (clr) begin
      lane_r <= 2'd0;
      word_r <= 32'd0;
    end else if (byte_en) begin
      word_r <= word;
      lane_r <= word_valid ? 2'd0 : lane_r + 2'd1;
    end else begin
      lane_r <= lane_r;
      word_r <= word_r;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: streams a length-prefixed image into imem and holds the CPU in reset until done.
// IMEM_LOADER_CSUM_EN adds a trailing XOR checksum byte that must match before the CPU is released.
module imem_loader import imem_loader_pkg::*; #(
  parameter int IMEM_WORDS = 1024,
  parameter int AW         = $clog2(IMEM_WORDS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_valid,
  input  logic [7:0]    s_data,
  output logic          s_ready,
  input  logic          load_req,
  output logic          imem_we,
  output logic [AW-1:0] imem_waddr,
  output logic [31:0]   imem_wdata,
  output logic          cpu_rst,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam logic [1:0] HDR_LAST  = 2'(LOADER_HDR_BYTES - 1);
  localparam logic [1:0] WORD_LAST = 2'(LOADER_WORD_BYTES - 1);
  localparam logic [AW:0] IDX_ONE  = {{AW{1'b0}}, 1'b1};

  loader_state_t state_r, next_state_s;
  logic [AW:0]   n_r, word_idx_r;
  logic          accept_s, pack_en_s, pack_clr_s, word_valid_s;
  logic [31:0]   word_s;
  logic [1:0]    last_lane_s;
`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0]    csum_r;
`endif

  assign accept_s    = s_valid && s_ready;
  assign pack_en_s   = accept_s && ((state_r == HDR) || (state_r == DATA));
  assign pack_clr_s  = load_req && ((state_r == DONE) || (state_r == ERROR));
  assign last_lane_s = (state_r == HDR) ? HDR_LAST : WORD_LAST;

  byte_word_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (pack_clr_s),
    .byte_en    (pack_en_s),
    .byte_in    (s_data),
    .last_lane  (last_lane_s),
    .word       (word_s),
    .word_valid (word_valid_s)
  );

  // Next-state logic for the header / payload / checksum sequence.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      HDR: begin
        if (word_valid_s) begin
          if (word_s > 32'(IMEM_WORDS)) begin
            next_state_s = ERROR;
          end else if (word_s == 32'd0) begin
`ifdef IMEM_LOADER_CSUM_EN
            next_state_s = CSUM;
`else
            next_state_s = DONE;
`endif
          end else begin
            next_state_s = DATA;
          end
        end else begin
          next_state_s = HDR;
        end
      end
      DATA: begin
        if (word_valid_s && ((word_idx_r + IDX_ONE) == n_r)) begin
`ifdef IMEM_LOADER_CSUM_EN
          next_state_s = CSUM;
`else
          next_state_s = DONE;
`endif
        end else begin
          next_state_s = DATA;
        end
      end
`ifdef IMEM_LOADER_CSUM_EN
      CSUM: begin
        if (accept_s) begin
          next_state_s = (s_data == csum_r) ? DONE : ERROR;
        end else begin
          next_state_s = CSUM;
        end
      end
`endif
      DONE, ERROR: begin
        if (load_req) begin
          next_state_s = HDR;
        end else begin
          next_state_s = state_r;
        end
      end
      default: next_state_s = HDR;
    endcase
  end

  // State register and registered status outputs; cpu_rst drops one cycle after DONE so the last write lands first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= HDR;
      s_ready <= 1'b1;
      busy    <= 1'b1;
      done    <= 1'b0;
      err     <= 1'b0;
      cpu_rst <= 1'b1;
    end else begin
      state_r <= next_state_s;
      s_ready <= (next_state_s == HDR) || (next_state_s == DATA) || (next_state_s == CSUM);
      busy    <= (next_state_s == HDR) || (next_state_s == DATA) || (next_state_s == CSUM);
      err     <= (next_state_s == ERROR);
      done    <= (state_r == DONE) && (next_state_s == DONE);
      cpu_rst <= !((state_r == DONE) && (next_state_s == DONE));
    end
  end

  // Word count, write index and one-cycle imem write strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_r        <= '0;
      word_idx_r <= '0;
      imem_we    <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= 32'd0;
    end else begin
      imem_we <= (state_r == DATA) && word_valid_s;
      if ((state_r == DATA) && word_valid_s) begin
        imem_waddr <= word_idx_r[AW-1:0];
        imem_wdata <= word_s;
      end else begin
        imem_waddr <= imem_waddr;
        imem_wdata <= imem_wdata;
      end
      if (pack_clr_s) begin
        n_r        <= '0;
        word_idx_r <= '0;
      end else begin
        n_r        <= ((state_r == HDR) && word_valid_s) ? word_s[AW:0] : n_r;
        word_idx_r <= ((state_r == DATA) && word_valid_s) ? word_idx_r + IDX_ONE : word_idx_r;
      end
    end
  end

`ifdef IMEM_LOADER_CSUM_EN
  // Running XOR over payload bytes only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_r <= 8'd0;
    end else if (pack_clr_s) begin
      csum_r <= 8'd0;
    end else if ((state_r == DATA) && accept_s) begin
      csum_r <= csum_update(csum_r, s_data);
    end else begin
      csum_r <= csum_r;
    end
  end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader; follows IMEM_LOADER_CSUM_EN for the checksum byte.
module tb_imem_loader;

  localparam int IMEM_WORDS = 1024;
  localparam int AW = 10;
`ifdef IMEM_LOADER_CSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic [7:0]    s_data = 8'd0;
  logic          load_req = 1'b0;
  logic          s_ready, imem_we, cpu_rst, busy, done, err;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;

  imem_loader #(.IMEM_WORDS(IMEM_WORDS), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .load_req(load_req), .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .cpu_rst(cpu_rst), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [AW-1:0] wr_addr [16];
  logic [31:0]   wr_data [16];
  int wr_cnt = 0;
  logic [7:0] img [32];
  int img_len = 0;
  logic [31:0] exp3 [3];

  // Capture every write strobe; a one-cycle pulse is seen at exactly one negedge.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      if (wr_cnt < 16) begin
        wr_addr[wr_cnt] = imem_waddr;
        wr_data[wr_cnt] = imem_wdata;
      end
      wr_cnt = wr_cnt + 1;
    end
  end

  task automatic put(input logic [7:0] b);
    img[img_len] = b;
    img_len++;
  endtask

  task automatic set_basic(input logic [7:0] cs);
    img_len = 0;
    put(8'h02); put(8'h00); put(8'h00); put(8'h00);
    put(8'h93); put(8'h00); put(8'ha0); put(8'h00);
    put(8'h23); put(8'h22); put(8'h10); put(8'h00);
    if (CSUM_EN) put(cs);
  endtask

  task automatic set_three();
    img_len = 0;
    put(8'h03); put(8'h00); put(8'h00); put(8'h00);
    put(8'h11); put(8'h22); put(8'h33); put(8'h44);
    put(8'h55); put(8'h66); put(8'h77); put(8'h88);
    put(8'h99); put(8'haa); put(8'hbb); put(8'hcc);
    if (CSUM_EN) put(8'hcc);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    s_valid = 1'b0;
    repeat (gap) @(negedge clk);
    s_valid = 1'b1;
    s_data  = b;
    t = 0;
    while (s_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) begin
      n_cmp++; n_bad++;
      $display("FAIL send_byte_timeout: s_ready=%b required 1", s_ready);
    end
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic stream(input int maxgap);
    for (int i = 0; i < img_len; i++) begin
      send_byte(img[i], (maxgap == 0) ? 0 : int'($urandom_range(0, maxgap)));
    end
  endtask

  task automatic wait_end(input string nm);
    int t;
    t = 0;
    while (done !== 1'b1 && err !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (t >= 40) begin n_bad++; $display("FAIL %s_timeout: done=%b err=%b required one of them 1", nm, done, err); end
  endtask

  task automatic pulse_load_req();
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    wr_cnt = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (cpu_rst !== 1'b1) begin n_bad++; $display("FAIL reset_cpu_rst: got %b required 1", cpu_rst); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL reset_busy: got %b required 1", busy); end
    n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL reset_s_ready: got %b required 1", s_ready); end
    n_cmp++; if (imem_we !== 1'b0) begin n_bad++; $display("FAIL reset_imem_we: got %b required 0", imem_we); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b required 0", done); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b required 0", err); end
  endtask

  task automatic check_basic_writes(input string nm);
    n_cmp++; if (wr_cnt !== 2) begin n_bad++; $display("FAIL %s_wr_cnt: got %0d required 2", nm, wr_cnt); end
    n_cmp++; if (wr_addr[0] !== 10'd0 || wr_data[0] !== 32'h00a00093) begin
      n_bad++; $display("FAIL %s_wr0: got %0d/%h required 0/00a00093", nm, wr_addr[0], wr_data[0]); end
    n_cmp++; if (wr_addr[1] !== 10'd1 || wr_data[1] !== 32'h00102223) begin
      n_bad++; $display("FAIL %s_wr1: got %0d/%h required 1/00102223", nm, wr_addr[1], wr_data[1]); end
  endtask

  task automatic test_basic();
    wr_cnt = 0;
    set_basic(8'h22);
    stream(0);
    wait_end("basic");
    check_basic_writes("basic");
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL basic_done: got %b required 1", done); end
    n_cmp++; if (cpu_rst !== 1'b0) begin n_bad++; $display("FAIL basic_cpu_rst: got %b required 0", cpu_rst); end
    n_cmp++; if (err !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL basic_err_busy: got %b%b required 00", err, busy); end
    n_cmp++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL basic_s_ready: got %b required 0", s_ready); end
  endtask

  task automatic test_done_holds();
    s_valid = 1'b1;
    s_data  = 8'h5a;
    repeat (3) @(negedge clk);
    n_cmp++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL done_s_ready: got %b required 0", s_ready); end
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL done_hold: got %b required 1", done); end
    n_cmp++; if (wr_cnt !== 2) begin n_bad++; $display("FAIL done_no_write: got %0d required 2", wr_cnt); end
    s_valid = 1'b0;
  endtask

  task automatic test_load_req_empty();
    pulse_load_req();
    n_cmp++; if (cpu_rst !== 1'b1) begin n_bad++; $display("FAIL reload_cpu_rst: got %b required 1", cpu_rst); end
    n_cmp++; if (done !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL reload_done_busy: got %b%b required 01", done, busy); end
    n_cmp++; if (s_ready !== 1'b1) begin n_bad++; $display("FAIL reload_s_ready: got %b required 1", s_ready); end
    img_len = 0;
    put(8'h00); put(8'h00); put(8'h00); put(8'h00);
    if (CSUM_EN) put(8'h00);
    stream(0);
    wait_end("empty");
    n_cmp++; if (done !== 1'b1 || err !== 1'b0) begin n_bad++; $display("FAIL empty_done: got done=%b err=%b required 1 0", done, err); end
    n_cmp++; if (cpu_rst !== 1'b0) begin n_bad++; $display("FAIL empty_cpu_rst: got %b required 0", cpu_rst); end
    n_cmp++; if (wr_cnt !== 0) begin n_bad++; $display("FAIL empty_wr_cnt: got %0d required 0", wr_cnt); end
  endtask

`ifdef IMEM_LOADER_CSUM_EN
  task automatic test_bad_csum();
    pulse_load_req();
    set_basic(8'h23);
    stream(0);
    wait_end("badcsum");
    n_cmp++; if (err !== 1'b1 || done !== 1'b0) begin n_bad++; $display("FAIL badcsum_err: got err=%b done=%b required 1 0", err, done); end
    n_cmp++; if (cpu_rst !== 1'b1) begin n_bad++; $display("FAIL badcsum_cpu_rst: got %b required 1", cpu_rst); end
    n_cmp++; if (s_ready !== 1'b0) begin n_bad++; $display("FAIL badcsum_s_ready: got %b required 0", s_ready); end
  endtask
`endif

  task automatic test_oversize();
    pulse_load_req();
    img_len = 0;
    put(8'h01); put(8'h04); put(8'h00); put(8'h00);
    stream(0);
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL oversize_err: got %b required 1", err); end
    n_cmp++; if (s_ready !== 1'b0 || cpu_rst !== 1'b1) begin n_bad++; $display("FAIL oversize_rdy_rst: got %b%b required 01", s_ready, cpu_rst); end
    repeat (3) @(negedge clk);
    n_cmp++; if (wr_cnt !== 0) begin n_bad++; $display("FAIL oversize_wr_cnt: got %0d required 0", wr_cnt); end
  endtask

  task automatic check_three(input string nm);
    n_cmp++; if (wr_cnt !== 3) begin n_bad++; $display("FAIL %s_wr_cnt: got %0d required 3", nm, wr_cnt); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (wr_addr[i] !== AW'(i) || wr_data[i] !== exp3[i]) begin
        n_bad++; $display("FAIL %s_wr%0d: got %0d/%h required %0d/%h", nm, i, wr_addr[i], wr_data[i], i, exp3[i]);
      end
    end
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL %s_done: got %b required 1", nm, done); end
  endtask

  task automatic test_gaps();
    exp3[0] = 32'h44332211;
    exp3[1] = 32'h88776655;
    exp3[2] = 32'hccbbaa99;
    pulse_load_req();
    set_three();
    stream(0);
    wait_end("gapless");
    check_three("gapless");
    pulse_load_req();
    stream(5);
    wait_end("gapped");
    check_three("gapped");
  endtask

  task automatic test_reset_mid();
    pulse_load_req();
    send_byte(8'h02, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    send_byte(8'hde, 0); send_byte(8'had, 0);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (cpu_rst !== 1'b1 || busy !== 1'b1) begin n_bad++; $display("FAIL midrst_rst_busy: got %b%b required 11", cpu_rst, busy); end
    n_cmp++; if (s_ready !== 1'b1 || done !== 1'b0) begin n_bad++; $display("FAIL midrst_rdy_done: got %b%b required 10", s_ready, done); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    wr_cnt = 0;
    set_basic(8'h22);
    stream(0);
    wait_end("midrst");
    check_basic_writes("midrst");
    n_cmp++; if (done !== 1'b1 || cpu_rst !== 1'b0) begin n_bad++; $display("FAIL midrst_done: got %b%b required 10", done, cpu_rst); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_done_holds();
    test_load_req_empty();
`ifdef IMEM_LOADER_CSUM_EN
    test_bad_csum();
`endif
    test_oversize();
    test_gaps();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
